// File: rtl/display_capture_sequencer.sv
// display_capture_sequencer
// Steps the display mux select through a window of debug codes, waits for the mux
// output to settle, then captures each 32-bit word with its index and a valid pulse.
// It advances automatically on a dwell timer or manually on a Step pulse.
// Optional feature macro: SNAPSHOT_BUFFER_EN adds a per-index snapshot array with a
// combinational read port (Read_Index / Read_Data).
// Timing: a select committed at edge E is held for SETTLE_CYCLES edges and the word is
// captured at edge E+SETTLE_CYCLES+1. In auto mode the sequencer then spends
// DWELL_CYCLES edges in DWELL before committing the next select.
module display_capture_sequencer #(
  parameter int SEL_BASE      = 32,
  parameter int SEL_COUNT     = 7,
  parameter int SETTLE_CYCLES = 2,
  parameter int DWELL_CYCLES  = 50_000_000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Step,
  input  logic        Auto_Mode,
  input  logic [31:0] Display_Data_In,
  output logic [5:0]  Display_Select,
  output logic        Display_Enable,
  output logic [31:0] Capture_Data,
  output logic [2:0]  Capture_Index,
  output logic        Capture_Valid,
  output logic        Busy,
  output logic        Done
`ifdef SNAPSHOT_BUFFER_EN
  ,
  input  logic [2:0]  Read_Index,
  output logic [31:0] Read_Data
`endif
);

  // Reject parameter sets the select path or counters cannot represent
  generate
    if (SEL_BASE < 0 || SEL_BASE + SEL_COUNT > 64) begin : g_bad_window
      $error("display_capture_sequencer: SEL_BASE+SEL_COUNT must not exceed 64");
    end
    if (SEL_COUNT < 1 || SEL_COUNT > 8) begin : g_bad_count
      $error("display_capture_sequencer: SEL_COUNT must be 1..8");
    end
    if (SETTLE_CYCLES < 1 || DWELL_CYCLES < 1) begin : g_bad_timing
      $error("display_capture_sequencer: SETTLE_CYCLES and DWELL_CYCLES must be >= 1");
    end
  endgenerate

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DWELL   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // One counter serves both the settle and the dwell phases
  localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST    = 3'(SEL_COUNT - 1);
  localparam logic [5:0]    BASE6       = 6'(SEL_BASE);

  logic [2:0]    state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          auto_reg, auto_next;
  logic          capture;
  logic          advance;

  // The sequencer never blanks the display; it only owns the select
  assign Display_Enable = 1'b0;

  // Next-state logic: scan control, settle/dwell counting and advance decision
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    auto_next  = auto_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // Start wins over a coincident Step; the mode is latched only here
        if (Start) begin
          state_next = ST_SELECT;
          idx_next   = 3'd0;
          cnt_next   = '0;
          auto_next  = Auto_Mode;
        end
      end
      ST_SELECT: begin
        if (cnt_reg == SETTLE_LAST) begin
          state_next = ST_CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_DWELL;
        cnt_next   = '0;
      end
      ST_DWELL: begin
        advance = auto_reg ? (cnt_reg == DWELL_LAST) : Step;
        if (auto_reg && !advance) begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (advance) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SELECT;
            idx_next   = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 3'd0;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counters and all registered outputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 3'd0;
      cnt_reg        <= '0;
      auto_reg       <= 1'b0;
      Display_Select <= BASE6;
      Capture_Data   <= 32'd0;
      Capture_Index  <= 3'd0;
      Capture_Valid  <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      auto_reg       <= auto_next;
      Display_Select <= BASE6 + {3'b000, idx_next};
      Capture_Valid  <= capture;
      if (capture) begin
        Capture_Data  <= Display_Data_In;
        Capture_Index <= idx_reg;
      end
      Busy <= (state_next == ST_SELECT) || (state_next == ST_CAPTURE) ||
              (state_next == ST_DWELL);
      Done <= (state_next == ST_DONE);
    end
  end

`ifdef SNAPSHOT_BUFFER_EN
  logic [31:0] snap_reg [SEL_COUNT];

  // Snapshot array: entry idx is overwritten at each capture, persists across scans
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SEL_COUNT; i++) begin
        snap_reg[i] <= 32'd0;
      end
    end else if (capture) begin
      snap_reg[idx_reg] <= Display_Data_In;
    end
  end

  // Combinational read; indices outside the window return a recognisable filler
  always_comb begin
    Read_Data = 32'hDEDE_DEDE;
    if ({1'b0, Read_Index} < 4'(SEL_COUNT)) begin
      Read_Data = snap_reg[Read_Index];
    end
  end
`endif

endmodule

// File: tb/tb_display_capture_sequencer.sv
// Testbench for display_capture_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against an event-timeline model of the scan.
module tb_display_capture_sequencer;

  localparam int S = 2;   // settle cycles
  localparam int D = 4;   // dwell cycles
  localparam int N = 7;   // select count
  localparam int B = 32;  // select base

  logic        Clock     = 1'b0;
  logic        Reset_n   = 1'b1;
  logic        Start     = 1'b0;
  logic        Step      = 1'b0;
  logic        Auto_Mode = 1'b0;
  logic [31:0] Display_Data_In;
  logic [5:0]  Display_Select;
  logic        Display_Enable;
  logic [31:0] Capture_Data;
  logic [2:0]  Capture_Index;
  logic        Capture_Valid;
  logic        Busy;
  logic        Done;
`ifdef SNAPSHOT_BUFFER_EN
  logic [2:0]  Read_Index = 3'd0;
  logic [31:0] Read_Data;
`endif

  // Behavioural stand-in for the display mux
  logic [31:0] mux_word [64];
  assign Display_Data_In = mux_word[Display_Select];

  always #5 Clock = ~Clock;

  display_capture_sequencer #(
    .SEL_BASE(B), .SEL_COUNT(N), .SETTLE_CYCLES(S), .DWELL_CYCLES(D)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Step(Step), .Auto_Mode(Auto_Mode),
    .Display_Data_In(Display_Data_In), .Display_Select(Display_Select),
    .Display_Enable(Display_Enable), .Capture_Data(Capture_Data),
    .Capture_Index(Capture_Index), .Capture_Valid(Capture_Valid), .Busy(Busy), .Done(Done)
`ifdef SNAPSHOT_BUFFER_EN
    , .Read_Index(Read_Index), .Read_Data(Read_Data)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: scan as a timeline of edge numbers ----------------
  int          cyc = 0;
  bit          m_active, m_done, m_dwell, m_auto, m_valid;
  int          m_idx, m_cap_edge, m_adv_edge, m_cap_idx;
  logic [31:0] m_cap_data;
  logic [31:0] m_snap [8];

  // captures observed on the DUT, for the directed literal checks
  int          log_edge [$];
  int          log_idx  [$];
  logic [31:0] log_data [$];

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_dwell = 0; m_auto = 0; m_valid = 0;
    m_idx = 0; m_cap_edge = -1; m_adv_edge = -1; m_cap_idx = 0; m_cap_data = 32'd0;
    for (int i = 0; i < 8; i++) m_snap[i] = 32'd0;
  endfunction

  function automatic void model_edge(input int e, input bit st, input bit sp, input bit au);
    logic [31:0] seen;
    seen    = mux_word[B + m_idx];
    m_valid = 0;
    if (!m_active) begin
      if (st) begin
        m_active = 1; m_done = 0; m_idx = 0; m_auto = au; m_dwell = 0;
        m_cap_edge = e + S + 1;
      end
    end else if (e == m_cap_edge) begin
      m_valid = 1; m_cap_data = seen; m_cap_idx = m_idx; m_snap[m_idx] = seen;
      m_dwell = 1; m_adv_edge = e + D;
    end else if (m_dwell && (m_auto ? (e == m_adv_edge) : sp)) begin
      m_dwell = 0;
      if (m_idx == N - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_idx++;
        m_cap_edge = e + S + 1;
      end
    end
  endfunction

  // Per-cycle compare process
  initial begin
    model_reset();
    forever begin
      @(posedge Clock);
      cyc++;
      if (!Reset_n) model_reset();
      else model_edge(cyc, Start, Step, Auto_Mode);
      #1;
      chk("select",  {26'd0, Display_Select}, 32'(B + m_idx));
      chk("enable",  {31'd0, Display_Enable}, 32'd0);
      chk("busy",    {31'd0, Busy},           {31'd0, m_active});
      chk("done",    {31'd0, Done},           {31'd0, m_done});
      chk("valid",   {31'd0, Capture_Valid},  {31'd0, m_valid});
      chk("cap_data", Capture_Data,           m_cap_data);
      chk("cap_idx", {29'd0, Capture_Index},  32'(m_cap_idx));
`ifdef SNAPSHOT_BUFFER_EN
      chk("read_data", Read_Data, (Read_Index < 3'(N)) ? m_snap[Read_Index] : 32'hDEDE_DEDE);
`endif
      if (Capture_Valid) begin
        log_edge.push_back(cyc);
        log_idx.push_back(int'(Capture_Index));
        log_data.push_back(Capture_Data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic pulse_step();
    Step = 1'b1; tick(); Step = 1'b0;
  endtask

  task automatic clear_log();
    log_edge.delete(); log_idx.delete(); log_data.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_idx.size() < n && k < budget) begin
      tick(); k++;
    end
    chk(name, 32'(log_idx.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (Done !== 1'b1 && k < budget) begin
      tick(); k++;
    end
    chk(name, {31'd0, Done}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    for (int s = 0; s < 64; s++) mux_word[s] = 32'h0000_1000 + 32'(s);

    // 1: reset values
    #2 Reset_n = 1'b0;
    tick(3);
    chk("rst_select", {26'd0, Display_Select}, 32'd32);
    chk("rst_enable", {31'd0, Display_Enable}, 32'd0);
    chk("rst_busy",   {31'd0, Busy}, 32'd0);
    chk("rst_done",   {31'd0, Done}, 32'd0);
    chk("rst_data",   Capture_Data, 32'd0);
    Reset_n = 1'b1;
    tick(2);

    // 2: auto scan over the whole window
    Auto_Mode = 1'b1;
    clear_log();
    t0 = cyc + 1;
    pulse_start();
    wait_log(7, 100, "auto_7_captures");
    if (log_idx.size() >= 7) begin
      chk("auto_first_latency", 32'(log_edge[0] - t0), 32'd3);
      chk("auto_first_data", log_data[0], 32'h0000_1020);
      chk("auto_first_idx", 32'(log_idx[0]), 32'd0);
      chk("auto_period", 32'(log_edge[1] - log_edge[0]), 32'd7);
      chk("auto_last_data", log_data[6], 32'h0000_1026);
      chk("auto_last_idx", 32'(log_idx[6]), 32'd6);
    end
    wait_done(20, "auto_done");
    chk("auto_busy_end", {31'd0, Busy}, 32'd0);
    chk("auto_count", 32'(log_idx.size()), 32'd7);
`ifdef SNAPSHOT_BUFFER_EN
    // 6: snapshot read-back
    Read_Index = 3'd5; #1;
    chk("snap_5", Read_Data, 32'h0000_1025);
    Read_Index = 3'd7; #1;
    chk("snap_7", Read_Data, 32'hDEDE_DEDE);
    tick();
`endif

    // 3: manual stepping; Start and Step together from DONE (Step dropped)
    clear_log();
    Auto_Mode = 1'b0;
    Start = 1'b1; Step = 1'b1; tick(); Start = 1'b0; Step = 1'b0;
    tick(8);
    chk("man_first_count", 32'(log_idx.size()), 32'd1);
    chk("man_stall_busy", {31'd0, Busy}, 32'd1);
    pulse_step();   // accepted in DWELL
    pulse_step();   // lands in SELECT: dropped
    tick(8);
    chk("man_step_dropped", 32'(log_idx.size()), 32'd2);
    pulse_step(); tick(6);
    pulse_step(); tick(6);
    chk("man_count_4", 32'(log_idx.size()), 32'd4);
    chk("man_idx_3", {29'd0, Capture_Index}, 32'd3);
    chk("man_select_35", {26'd0, Display_Select}, 32'd35);
    Auto_Mode = 1'b1;  // mid-scan mode change: no effect
    tick(20);
    chk("man_mode_latched", 32'(log_idx.size()), 32'd4);
    repeat (4) begin pulse_step(); tick(6); end
    chk("man_done", {31'd0, Done}, 32'd1);
    chk("man_total", 32'(log_idx.size()), 32'd7);

    // 4: Start while busy is ignored
    clear_log();
    Auto_Mode = 1'b1;
    pulse_start();
    wait_log(3, 100, "mid_start_reach_idx2");
    pulse_start();
    wait_log(4, 50, "mid_start_next");
    if (log_idx.size() >= 4) chk("mid_start_idx3", 32'(log_idx[3]), 32'd3);
    wait_done(100, "mid_start_done");

    // 5: asynchronous reset mid-scan
    clear_log();
    pulse_start();
    wait_log(5, 100, "rst_mid_reach_idx4");
    Reset_n = 1'b0;
    #1;
    chk("rst_mid_select", {26'd0, Display_Select}, 32'd32);
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mid_done", {31'd0, Done}, 32'd0);
    tick(2);
    Reset_n = 1'b1;
    clear_log();
    t0 = cyc + 1;
    pulse_start();
    wait_log(1, 20, "rst_restart");
    if (log_idx.size() >= 1) begin
      chk("rst_restart_idx", 32'(log_idx[0]), 32'd0);
      chk("rst_restart_lat", 32'(log_edge[0] - t0), 32'd3);
    end

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      Start = ($urandom_range(0, 19) == 0);
      Step  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) Auto_Mode = ~Auto_Mode;
      if ($urandom_range(0, 49) == 0)
        for (int s = 0; s < 64; s++) mux_word[s] = $urandom;
`ifdef SNAPSHOT_BUFFER_EN
      Read_Index = 3'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 499) == 0) begin
        Start = 1'b0; Step = 1'b0;
        Reset_n = 1'b0; tick(2); Reset_n = 1'b1;
      end
      tick();
    end
    Start = 1'b0; Step = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
